// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// The FSM encoding matches the documented 2-bit state values.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_ALIGN_BITS = 2;
    localparam int CNT_WIDTH       = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data memory responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall;
    logic                  ack;
    logic                  err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, stall, ack, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, stall, ack, err
    );
endinterface

// File: rtl/data_mem_responder_sync_ram.sv
// Single-port word RAM; dout is registered and only refreshed by reads.
// Contents are deliberately not reset.
module sync_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_r [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] dout_r;

    // Array write or registered read, one per enabled edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= din;
            end else begin
                dout_r <= mem_r[addr];
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: services one load/store at a time with
// WAIT_CYCLES wait states, stalling the pipeline until the access completes.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int AW = DEPTH_LOG2 + WORD_ALIGN_BITS;

    state_t                 state_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [AW-1:0]          addr_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic                   write_r;
    logic                   ack_r;
    logic                   err_r;
    logic                   rdata_sel_r;

    logic                   req_s;
    logic                   issue_s;
    logic                   acc_write_s;
    logic [AW-1:0]          acc_addr_s;
    logic [DATA_WIDTH-1:0]  acc_wdata_s;
    logic                   misalign_s;
    logic [DATA_WIDTH-1:0]  ram_dout_s;
    logic                   addr_hi_unused_s;

    assign req_s            = bus.mem_read | bus.mem_write;
    assign addr_hi_unused_s = ^bus.addr[ADDR_WIDTH-1:AW];

    // Select the access issued on the edge that enters DONE; with zero wait
    // states that edge is the request edge itself, so live inputs are used.
    always_comb begin
        issue_s     = 1'b0;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_write_s = write_r;
        case (state_r)
            IDLE: begin
                if (req_s && (WAIT_CYCLES == 0)) begin
                    issue_s     = 1'b1;
                    acc_addr_s  = bus.addr[AW-1:0];
                    acc_wdata_s = bus.wdata;
                    acc_write_s = bus.mem_write;
                end else begin
                    issue_s     = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    assign misalign_s = |acc_addr_s[WORD_ALIGN_BITS-1:0];

    sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .en   (issue_s & ~misalign_s),
        .we   (acc_write_s),
        .addr (acc_addr_s[AW-1:WORD_ALIGN_BITS]),
        .din  (acc_wdata_s),
        .dout (ram_dout_s)
    );

    // Control FSM, wait counter and registered completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_WIDTH{1'b0}};
            addr_r      <= {AW{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            write_r     <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            rdata_sel_r <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        addr_r  <= bus.addr[AW-1:0];
                        wdata_r <= bus.wdata;
                        write_r <= bus.mem_write;
                        if (WAIT_CYCLES == 0) begin
                            state_r <= DONE;
                            cnt_r   <= {CNT_WIDTH{1'b0}};
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= CNT_WIDTH'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // rdata shows RAM output after an aligned load, zero after any
            // misaligned access, and is left alone by aligned stores.
            if (issue_s) begin
                ack_r <= 1'b1;
                err_r <= misalign_s;
                if (misalign_s) begin
                    rdata_sel_r <= 1'b0;
                end else if (!acc_write_s) begin
                    rdata_sel_r <= 1'b1;
                end else begin
                    rdata_sel_r <= rdata_sel_r;
                end
            end
        end
    end

    assign bus.stall = ~rst & (((state_r == IDLE) & req_s) | (state_r == BUSY));
    assign bus.ack   = ack_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_sel_r ? ram_dout_s : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance driven from
// a vector table plus hand sequences, and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();
    data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();

    data_mem_responder #(.WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            if0.mem_read = rd; if0.mem_write = wr; if0.addr = a; if0.wdata = d;
        end else begin
            if2.mem_read = rd; if2.mem_write = wr; if2.addr = a; if2.wdata = d;
        end
    endtask

    // sel=0 -> WAIT_CYCLES=2 instance, sel=1 -> WAIT_CYCLES=0 instance.
    task automatic access(input bit sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_stalls, input bit exp_err,
                          input logic [31:0] exp_rd, input string name);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        @(posedge clk); #1;
        drive(sel, rd, wr, a, d);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if ((sel ? if0.ack : if2.ack) === 1'b1) begin
                got = 1'b1;
            end else begin
                if ((sel ? if0.stall : if2.stall) === 1'b1) n++;
                @(posedge clk); #1;
            end
        end
        check({name, " ack_seen"}, {31'd0, got}, 32'd1);
        check({name, " stall_cycles"}, n, exp_stalls);
        check({name, " stall_in_ack"}, {31'd0, sel ? if0.stall : if2.stall}, 32'd0);
        check({name, " err"}, {31'd0, sel ? if0.err : if2.err}, {31'd0, exp_err});
        check({name, " rdata"}, sel ? if0.rdata : if2.rdata, exp_rd);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //                rd    wr    addr           wdata          err   rdata
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0002, 1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0001};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0002};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0055, 1'b1, 32'h0000_0000};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_A5A5, 1'b0, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_A5A5};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_0401, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0002};
        tbl[12] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0033, 1'b0, 32'h0000_0002};
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h0000_0033};
        tbl[14] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0000_0077, 1'b0, 32'h0000_0033};
        tbl[15] = '{1'b1, 1'b0, 32'hFFFF_F7FC, 32'h0000_0000, 1'b0, 32'h0000_0077};

        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset stall", {31'd0, if2.stall}, 32'd0);
        check("reset ack",   {31'd0, if2.ack},   32'd0);
        check("reset err",   {31'd0, if2.err},   32'd0);
        check("reset rdata", if2.rdata,          32'd0);
        check("reset rdata0", if0.rdata,         32'd0);

        for (int i = 0; i < 16; i++) begin
            access(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                   3, tbl[i].err, tbl[i].rdata, $sformatf("vec%0d", i));
        end

        // Zero-wait-state instance: one stall cycle, ack on the next.
        access(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_1234, 1, 1'b0, 32'h0, "w0 store");
        access(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1, 1'b0, 32'h0000_1234, "w0 load");

        // Reset while a store is in BUSY: the store must be discarded.
        access(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0011, 3, 1'b0, 32'h0000_0077, "pre store");
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0077);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid busy stall", {31'd0, if2.stall}, 32'd1);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("rst_mid stall drop", {31'd0, if2.stall}, 32'd0);
        check("rst_mid ack",        {31'd0, if2.ack},   32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit saw_ack;
            saw_ack = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (if2.ack !== 1'b0 || if2.stall !== 1'b0) saw_ack = 1'b1;
            end
            check("rst_mid quiet after", {31'd0, saw_ack}, 32'd0);
        end
        access(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 3, 1'b0, 32'h0000_0011, "post rst load");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
